obstacle_lanes: RTL

OBSTACLE_LANES -- requirements
Module: obstacle_lanes

---
 rtl/obstacle_lanes.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/obstacle_lanes.sv
// Obstacle lane mover: NB_LANES horizontal lanes stepping on a score-scaled tick.
// Optional pause input is enabled by defining OBSTACLE_PAUSE_EN.

module obstacle_lane #(
  parameter int X_WIDTH = 10,
  parameter int MAX_X   = 608,
  parameter int RST_X   = 0
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Move,
  input  logic               i_Dir,
  input  logic [2:0]         i_Step,
  output logic [X_WIDTH-1:0] o_X,
  output logic               o_Wrap
);

  localparam logic [X_WIDTH:0]   MAX_W = (X_WIDTH+1)'(MAX_X);
  localparam logic [X_WIDTH-1:0] MAX_N = X_WIDTH'(MAX_X);

  logic [X_WIDTH-1:0] x_q, x_d;
  logic               wrap_q, wrap_d;
  logic [X_WIDTH:0]   x_w, step_w, sum_w;

  // One extra bit keeps x+step from overflowing before the clamp compare.
  assign x_w    = {1'b0, x_q};
  assign step_w = (X_WIDTH+1)'(i_Step);
  assign sum_w  = x_w + step_w;

  always_comb begin
    x_d    = x_q;
    wrap_d = 1'b0;
    if (i_Move && (i_Step != 3'd0)) begin
      if (!i_Dir) begin
        if (x_w >= MAX_W) begin
          x_d    = '0;
          wrap_d = 1'b1;
        end else if (sum_w > MAX_W) begin
          x_d = MAX_N;
        end else begin
          x_d = sum_w[X_WIDTH-1:0];
        end
      end else begin
        if (x_w == '0) begin
          x_d    = MAX_N;
          wrap_d = 1'b1;
        end else if (x_w < step_w) begin
          x_d = '0;
        end else begin
          x_d = x_q - X_WIDTH'(i_Step);
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      x_q    <= X_WIDTH'(RST_X);
      wrap_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_X    = x_q;
  assign o_Wrap = wrap_q;

endmodule

module obstacle_lanes #(
  parameter int NB_LANES       = 4,
  parameter int X_WIDTH        = 10,
  parameter int H_VISIBLE_AREA = 640,
  parameter int TILE_SIZE      = 32,
  parameter int BASE_PERIOD    = 781250,
  parameter int CNT_WIDTH      = 20,
  parameter int X_BASE         = 0,
  parameter int LANE_SPACING   = 42
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset,
  input  logic [NB_LANES-1:0]          i_Reverse,
  input  logic [3*NB_LANES-1:0]        i_Step,
  input  logic [6:0]                   i_Score,
  input  logic                         i_Level_Up,
`ifdef OBSTACLE_PAUSE_EN
  input  logic                         i_Pause,
`endif
  output logic [X_WIDTH*NB_LANES-1:0]  o_Car_X,
  output logic                         o_Tick,
  output logic [NB_LANES-1:0]          o_Wrap
);

  localparam int MAX_X = H_VISIBLE_AREA - TILE_SIZE;
  localparam logic [CNT_WIDTH-1:0] P0  = CNT_WIDTH'(BASE_PERIOD);
  localparam logic [CNT_WIDTH-1:0] P1  = CNT_WIDTH'(BASE_PERIOD >> 1);
  localparam logic [CNT_WIDTH-1:0] P2  = CNT_WIDTH'(BASE_PERIOD >> 2);
  localparam logic [CNT_WIDTH-1:0] P3  = CNT_WIDTH'(BASE_PERIOD >> 3);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] r_period_q, r_period_d;
  logic [NB_LANES-1:0]  r_dir_q, r_dir_d;
  logic                 tick_q, tick_d;
  logic                 first_q, first_d;
  logic [CNT_WIDTH-1:0] sel_period;
  logic                 run;

  logic [NB_LANES-1:0][X_WIDTH-1:0] lane_x;
  logic [NB_LANES-1:0]              lane_wrap;

`ifdef OBSTACLE_PAUSE_EN
  assign run = ~i_Pause;
`else
  assign run = 1'b1;
`endif

  always_comb begin
    if (i_Score <= 7'd3)      sel_period = P0;
    else if (i_Score <= 7'd6) sel_period = P1;
    else if (i_Score <= 7'd9) sel_period = P2;
    else                      sel_period = P3;
  end

  // The period is only resampled when the count restarts, so a score change
  // never stretches or shortens the tick already in progress.
  always_comb begin
    cnt_d      = cnt_q;
    r_period_d = r_period_q;
    r_dir_d    = r_dir_q;
    tick_d     = 1'b0;
    first_d    = 1'b0;
    if (run) begin
      if (cnt_q == r_period_q - ONE) begin
        tick_d     = 1'b1;
        cnt_d      = '0;
        r_period_d = sel_period;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    if (i_Level_Up) begin
      cnt_d      = '0;
      r_period_d = sel_period;
    end
    if (first_q || i_Level_Up) r_dir_d = i_Reverse;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q      <= '0;
      r_period_q <= P0;
      r_dir_q    <= '0;
      tick_q     <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      r_period_q <= r_period_d;
      r_dir_q    <= r_dir_d;
      tick_q     <= tick_d;
      first_q    <= first_d;
    end
  end

  // Lanes move with r_dir_q, i.e. the direction in force before any
  // coincident level-up reload.
  for (genvar g = 0; g < NB_LANES; g++) begin : g_lane
    localparam int RAW_X = X_BASE + g * LANE_SPACING;
    localparam int RST_X = (RAW_X > MAX_X) ? MAX_X : RAW_X;
    obstacle_lane #(
      .X_WIDTH (X_WIDTH),
      .MAX_X   (MAX_X),
      .RST_X   (RST_X)
    ) u_lane (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Move  (tick_d),
      .i_Dir   (r_dir_q[g]),
      .i_Step  (i_Step[3*g +: 3]),
      .o_X     (lane_x[g]),
      .o_Wrap  (lane_wrap[g])
    );
  end

  assign o_Car_X = lane_x;
  assign o_Tick  = tick_q;
  assign o_Wrap  = lane_wrap;

endmodule
